uart_rx_frame: RTL and testbench

Single-clock UART receive framer that turns the serial `rx` line into parallel bytes with per-frame error flags. It runs at 16× oversampling, driven by a sample-tick enable from the baud divider. It sits between the pad-side `rx` input and the receive FIFO write port, which it drives through a valid/ready handshake. It uses the same `parity_mode`/`stop_bit` encoding as the UART config register.

---
 rtl/uart_rx_frame_pkg.sv | 29 ++
 rtl/uart_rx_sampler.sv | 39 +++
 rtl/uart_rx_frame.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_frame.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_frame_pkg.sv
// rtl/uart_rx_frame_pkg.sv - configuration codes and receiver state encoding
package uart_rx_frame_pkg;

   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_EVEN = 2'd1;
   localparam logic [1:0] PAR_ODD  = 2'd2;

   localparam logic [1:0] STOP_1 = 2'd0;
   localparam logic [1:0] STOP_2 = 2'd1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } rx_state_e;

   // Code 3 is reserved and behaves as no parity.
   function automatic logic parity_on(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

   function automatic logic two_stops(input logic [1:0] mode);
      return mode >= STOP_2;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - rx synchronizer and mid-bit 2-of-3 majority vote
module uart_rx_sampler #(
   parameter int OVERSAMPLE = 16,
   parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sample_tick,
   input  logic             rx,
   input  logic [CNT_W-1:0] cnt,
   output logic             rx_sync,
   output logic             bit_vote
);

   localparam logic [CNT_W-1:0] SAMPLE_A = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] SAMPLE_B = CNT_W'(OVERSAMPLE / 2);

   logic rx_meta;
   logic samp_a;
   logic samp_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         samp_a  <= 1'b1;
         samp_b  <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         if (sample_tick && cnt == SAMPLE_A) samp_a <= rx_sync;
         if (sample_tick && cnt == SAMPLE_B) samp_b <= rx_sync;
      end
   end

   // The third sample is the live one, so the vote is valid on the decision tick itself.
   assign bit_vote = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - 16x oversampled UART receive framer with per-byte error flags
module uart_rx_frame
   import uart_rx_frame_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sample_tick,
   input  logic                 rx,
   input  logic [1:0]           parity_mode,
   input  logic [1:0]           stop_bit,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 break_det,
   output logic                 overrun,
   input  logic                 err_clr
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int IDX_W = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] VOTE_CNT = CNT_W'(OVERSAMPLE / 2 + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

   rx_state_e            state;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [1:0]           par_cfg;
   logic [1:0]           stop_cfg;
   logic                 second_stop;
   logic [DATA_BITS-1:0] shift;
   logic                 perr_p;
   logic                 ferr_p;
   logic                 any_one;
   logic                 rx_sync;
   logic                 bit_vote;
   logic                 vote;
   logic                 exp_par;
   logic                 frame_end;

   uart_rx_sampler #(
      .OVERSAMPLE(OVERSAMPLE),
      .CNT_W     (CNT_W)
   ) u_sampler (
      .clk        (clk),
      .rst        (rst),
      .sample_tick(sample_tick),
      .rx         (rx),
      .cnt        (cnt),
      .rx_sync    (rx_sync),
      .bit_vote   (bit_vote)
   );

   assign vote      = sample_tick && (cnt == VOTE_CNT);
   assign exp_par   = (par_cfg == PAR_ODD) ? ~^shift : ^shift;
   assign frame_end = vote && (state == STOP) && (second_stop || !two_stops(stop_cfg));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         par_cfg     <= PAR_NONE;
         stop_cfg    <= STOP_1;
         second_stop <= 1'b0;
         shift       <= '0;
         perr_p      <= 1'b0;
         ferr_p      <= 1'b0;
         any_one     <= 1'b0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         break_det   <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (rx_valid && rx_ready) rx_valid <= 1'b0;
         if (err_clr) overrun <= 1'b0;

         // A same-cycle accept frees the holding register, so the new frame lands instead of overrunning.
         if (frame_end) begin
            if (!rx_valid || rx_ready) begin
               rx_data    <= shift;
               parity_err <= perr_p;
               frame_err  <= ferr_p | ~bit_vote;
               break_det  <= ~(any_one | bit_vote);
               rx_valid   <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end

         if (sample_tick) begin
            cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
            unique case (state)
               IDLE: begin
                  cnt <= '0;
                  if (!rx_sync) begin
                     // The detect tick is sample 0 of the start bit.
                     state       <= START;
                     cnt         <= CNT_W'(1);
                     par_cfg     <= parity_mode;
                     stop_cfg    <= stop_bit;
                     bit_idx     <= '0;
                     second_stop <= 1'b0;
                     perr_p      <= 1'b0;
                     ferr_p      <= 1'b0;
                     any_one     <= 1'b0;
                  end
               end
               START: begin
                  if (vote && bit_vote) begin
                     state <= IDLE;
                     cnt   <= '0;
                  end else if (cnt == LAST_CNT) begin
                     state <= DATA;
                  end
               end
               DATA: begin
                  if (vote) begin
                     shift   <= {bit_vote, shift[DATA_BITS-1:1]};
                     any_one <= any_one | bit_vote;
                  end
                  if (cnt == LAST_CNT) begin
                     if (bit_idx == LAST_BIT) state <= parity_on(par_cfg) ? PARITY : STOP;
                     else bit_idx <= bit_idx + 1'b1;
                  end
               end
               PARITY: begin
                  if (vote) begin
                     perr_p  <= (bit_vote != exp_par);
                     any_one <= any_one | bit_vote;
                  end
                  if (cnt == LAST_CNT) state <= STOP;
               end
               STOP: begin
                  if (frame_end) begin
                     state <= rx_sync ? IDLE : WAIT_HIGH;
                     cnt   <= '0;
                  end else if (vote) begin
                     ferr_p      <= ferr_p | ~bit_vote;
                     any_one     <= any_one | bit_vote;
                     second_stop <= 1'b1;
                  end
               end
               WAIT_HIGH: begin
                  cnt <= '0;
                  if (rx_sync) state <= IDLE;
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - directed and randomized bench for uart_rx_frame
module tb_uart_rx_frame;

   localparam int OS = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sample_tick = 1'b0;
   logic       rx = 1'b1;
   logic       rx_ready = 1'b0;
   logic       err_clr = 1'b0;
   logic [1:0] parity_mode = 2'd0;
   logic [1:0] stop_bit = 2'd0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       parity_err;
   logic       frame_err;
   logic       break_det;
   logic       overrun;

   int n_assert = 0;
   int n_fail = 0;

   logic       pre_valid;
   logic       cap_valid;
   logic [7:0] cap_data;
   logic       cap_perr;
   logic       cap_ferr;
   logic       cap_brk;
   logic       cap_ovr;

   uart_rx_frame #(
      .OVERSAMPLE(OS),
      .DATA_BITS (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sample_tick(sample_tick),
      .rx         (rx),
      .parity_mode(parity_mode),
      .stop_bit   (stop_bit),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .break_det  (break_det),
      .overrun    (overrun),
      .err_clr    (err_clr)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         repeat (3) @(negedge clk);
         sample_tick = 1'b1;
         @(negedge clk);
         sample_tick = 1'b0;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         while (!sample_tick) @(posedge clk);
      end
      #1;
   endtask

   // Reference: flags derived from the transmitted line contents. Returns {break, frame, parity}.
   function automatic logic [2:0] model_flags(input logic [7:0] d, input logic [1:0] pm,
                                              input logic [1:0] sm, input logic pbit,
                                              input logic [1:0] stops);
      logic pen, want, perr, ferr, brk;
      pen  = (pm == 2'd1) || (pm == 2'd2);
      want = (pm == 2'd2) ? ~^d : ^d;
      perr = pen && (pbit != want);
      ferr = !stops[0] || (sm != 2'd0 && !stops[1]);
      brk  = (d == 8'h00) && (!pen || !pbit) && !stops[0] && (sm == 2'd0 || !stops[1]);
      return {brk, ferr, perr};
   endfunction

   // Drives one frame starting just after a tick edge; snapshots outputs one tick before and
   // on the tick of the final stop vote.
   task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic [1:0] sm,
                             input logic pbit, input logic [1:0] stops,
                             input logic accept_end, input int abort_bit);
      logic bits[$];
      logic saved_ready;
      parity_mode = pm;
      stop_bit    = sm;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (pm == 2'd1 || pm == 2'd2) bits.push_back(pbit);
      bits.push_back(stops[0]);
      if (sm != 2'd0) bits.push_back(stops[1]);
      for (int k = 0; k < bits.size(); k++) begin
         rx = bits[k];
         if (k == 1) begin
            parity_mode = 2'($urandom);
            stop_bit    = 2'($urandom);
         end
         if (k == abort_bit) begin
            wait_ticks(OS / 2);
            rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            rx = 1'b1;
            return;
         end
         if (k == bits.size() - 1) begin
            wait_ticks(OS / 2 + 1);
            pre_valid = rx_valid;
            repeat (3) @(posedge clk);
            #1;
            saved_ready = rx_ready;
            if (accept_end) rx_ready = 1'b1;
            wait_ticks(1);
            cap_valid = rx_valid;
            cap_data  = rx_data;
            cap_perr  = parity_err;
            cap_ferr  = frame_err;
            cap_brk   = break_det;
            cap_ovr   = overrun;
            rx_ready  = saved_ready;
            wait_ticks(OS / 2 - 2);
         end else begin
            wait_ticks(OS);
         end
      end
   endtask

   task automatic check_frame(input string tag, input logic [7:0] d, input logic [1:0] pm,
                              input logic [1:0] sm, input logic pbit, input logic [1:0] stops);
      logic [2:0] f;
      f = model_flags(d, pm, sm, pbit, stops);
      check({tag, " valid one tick early"}, 32'(pre_valid), 32'd0);
      check({tag, " valid at last stop vote"}, 32'(cap_valid), 32'd1);
      check({tag, " data"}, 32'(cap_data), 32'(d));
      check({tag, " parity_err"}, 32'(cap_perr), 32'(f[0]));
      check({tag, " frame_err"}, 32'(cap_ferr), 32'(f[1]));
      check({tag, " break_det"}, 32'(cap_brk), 32'(f[2]));
      check({tag, " overrun"}, 32'(cap_ovr), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " rx_valid"}, 32'(rx_valid), 32'd0);
      check({tag, " rx_data"}, 32'(rx_data), 32'd0);
      check({tag, " parity_err"}, 32'(parity_err), 32'd0);
      check({tag, " frame_err"}, 32'(frame_err), 32'd0);
      check({tag, " break_det"}, 32'(break_det), 32'd0);
      check({tag, " overrun"}, 32'(overrun), 32'd0);
   endtask

   initial begin
      logic [7:0] d;
      logic [1:0] pm, sm, st;
      logic       pb;

      repeat (4) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      rx_ready = 1'b1;
      wait_ticks(3);

      send_frame(8'hA5, 2'd0, 2'd0, 1'b0, 2'b11, 1'b0, -1);
      check_frame("8N1 A5", 8'hA5, 2'd0, 2'd0, 1'b0, 2'b11);

      send_frame(8'h03, 2'd1, 2'd0, 1'b1, 2'b11, 1'b0, -1);
      check_frame("even bad parity 03", 8'h03, 2'd1, 2'd0, 1'b1, 2'b11);
      send_frame(8'h03, 2'd2, 2'd0, 1'b1, 2'b11, 1'b0, -1);
      check_frame("odd good parity 03", 8'h03, 2'd2, 2'd0, 1'b1, 2'b11);

      send_frame(8'h55, 2'd0, 2'd0, 1'b0, 2'b00, 1'b0, -1);
      check_frame("stop low 55", 8'h55, 2'd0, 2'd0, 1'b0, 2'b00);
      rx = 1'b1;
      wait_ticks(OS);

      send_frame(8'h00, 2'd0, 2'd0, 1'b0, 2'b00, 1'b0, -1);
      check_frame("break", 8'h00, 2'd0, 2'd0, 1'b0, 2'b00);
      rx_ready = 1'b0;
      wait_ticks(OS * 12);
      check("no retrigger while line low", 32'(rx_valid), 32'd0);
      rx = 1'b1;
      wait_ticks(OS * 2);
      check("no frame after break release", 32'(rx_valid), 32'd0);

      rx = 1'b0;
      wait_ticks(5);
      rx = 1'b1;
      wait_ticks(OS * 3);
      check("glitch rejected", 32'(rx_valid), 32'd0);
      rx_ready = 1'b1;
      send_frame(8'h3C, 2'd0, 2'd0, 1'b0, 2'b11, 1'b0, -1);
      check_frame("after glitch 3C", 8'h3C, 2'd0, 2'd0, 1'b0, 2'b11);

      for (int n = 0; n < 12; n++) begin
         d  = 8'($urandom);
         pm = 2'($urandom);
         sm = 2'($urandom);
         pb = ((pm == 2'd2) ? ~^d : ^d) ^ ($urandom_range(0, 2) == 0);
         st = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
         send_frame(d, pm, sm, pb, st, 1'b0, -1);
         check_frame($sformatf("random %0d d=%02h pm=%0d sm=%0d", n, d, pm, sm), d, pm, sm, pb, st);
         if (!st[0] || !st[1]) begin
            rx = 1'b1;
            wait_ticks(OS);
         end
      end

      rx_ready = 1'b0;
      send_frame(8'h11, 2'd0, 2'd0, 1'b0, 2'b11, 1'b0, -1);
      check("held 11 valid", 32'(cap_valid), 32'd1);
      check("held 11 data", 32'(cap_data), 32'h11);
      send_frame(8'h22, 2'd0, 2'd0, 1'b0, 2'b11, 1'b0, -1);
      check("overrun data kept", 32'(cap_data), 32'h11);
      check("overrun valid kept", 32'(cap_valid), 32'd1);
      check("overrun set", 32'(cap_ovr), 32'd1);
      rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
      check("valid drops after accept", 32'(rx_valid), 32'd0);
      check("overrun sticky", 32'(overrun), 32'd1);
      err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
      check("overrun cleared", 32'(overrun), 32'd0);
      wait_ticks(1);

      send_frame(8'h5A, 2'd0, 2'd0, 1'b0, 2'b11, 1'b0, -1);
      send_frame(8'h6B, 2'd0, 2'd0, 1'b0, 2'b11, 1'b1, -1);
      check("accept+complete valid", 32'(cap_valid), 32'd1);
      check("accept+complete data", 32'(cap_data), 32'h6B);
      check("accept+complete no overrun", 32'(cap_ovr), 32'd0);

      send_frame(8'h44, 2'd0, 2'd0, 1'b0, 2'b11, 1'b0, -1);
      check("pre-reset overrun", 32'(cap_ovr), 32'd1);
      send_frame(8'hFF, 2'd0, 2'd0, 1'b0, 2'b11, 1'b0, 5);
      check_reset_outputs("mid-frame reset");
      wait_ticks(OS * 2);
      rx_ready = 1'b1;
      send_frame(8'h81, 2'd0, 2'd0, 1'b0, 2'b11, 1'b0, -1);
      check_frame("after reset 81", 8'h81, 2'd0, 2'd0, 1'b0, 2'b11);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
